// File: rtl/gmii_rx_defs.sv
// Shared definitions for the GMII receive sink: FSM states, framing bytes,
// FIFO entry layout and the saturating length helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package gmii_rx_defs;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    TAIL = 3'd3,
    DROP = 3'd4
  } state_t;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  localparam int ENTRY_W = 10;
  localparam int LEN_W   = 11;
  localparam logic [LEN_W-1:0] LEN_SAT = 11'd2047;

  // One FIFO slot, {err,last,data}; err is only meaningful with last.
  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } entry_t;

  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
    return (l == LEN_SAT) ? l : l + 11'd1;
  endfunction

endpackage

// File: rtl/gmii_rx_sink_if.sv
// GMII receive input plus the valid/ready payload byte stream out of the sink.
// Latency: n/a (wiring only). Backpressure: out_ready from the consumer.
// master = environment (receiver + downstream consumer); slave = gmii_rx_sink.
interface gmii_rx_sink_if;
  logic       RX_DV;
  logic       RX_ER;
  logic [7:0] RXD;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_err;

  modport master (
    output RX_DV, RX_ER, RXD, out_ready,
    input  out_valid, out_data, out_last, out_err
  );

  modport slave (
    input  RX_DV, RX_ER, RXD, out_ready,
    output out_valid, out_data, out_last, out_err
  );
endinterface

// File: rtl/gmii_rx_fifo.sv
// Synchronous DEPTH x 10 FIFO holding {err,last,data} payload entries.
// Latency: a push is visible at the head the cycle after its write edge.
// Backpressure: push ignored while full (even with a same-cycle pop); head holds last popped value when empty.
// Ports: clk, rst (async active-low), push/push_dat, pop, head_dat, full, empty.
module gmii_rx_fifo
  import gmii_rx_defs::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_dat,
  input  logic   pop,
  output entry_t head_dat,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        last_dat;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit tells full from empty when the addresses match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_dat <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_dat <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // When empty the stale slot at rd_ptr is not the last value shown, so
  // present the copy taken at the final pop instead.
  assign head_dat = empty ? last_dat : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gmii_rx_sink.sv
// GMII receive endpoint: strips preamble/SFD, queues payload bytes with last/err, counts frames.
// Latency: RXD byte in cycle c is on out_data with out_valid in cycle c+2 (hold reg + FIFO write).
// Backpressure: out_ready pops the FIFO; data bytes pushed while full are dropped (frame marked bad), the tail waits in TAIL.
// Ports: clk, rst (async active-low), bus (RX_DV/RX_ER/RXD in, out_* stream), frame_ok_cnt, frame_err_cnt, last_len.
module gmii_rx_sink
  import gmii_rx_defs::*;
#(
  parameter int DEPTH   = 16,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int PRE_MAX = 7
) (
  input  logic          clk,
  input  logic          rst,
  gmii_rx_sink_if.slave bus,
  output logic [15:0]   frame_ok_cnt,
  output logic [15:0]   frame_err_cnt,
  output logic [10:0]   last_len
);

  state_t           state, state_nxt;
  logic [3:0]       pre_cnt, pre_nxt;
  logic [7:0]       hold_dat, hold_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             bad, bad_nxt;
  logic             ovf, ovf_nxt;
  logic             tail_dv, tail_dv_nxt;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic             frame_err;
  logic             ok_inc;
  logic [1:0]       err_inc;
  logic             len_upd;
  entry_t           push_dat, head;

  assign frame_err = bad | ovf | (len < 11'(MIN_LEN)) | (len > 11'(MAX_LEN));

  always_comb begin
    state_nxt   = state;
    pre_nxt     = pre_cnt;
    hold_nxt    = hold_dat;
    len_nxt     = len;
    bad_nxt     = bad;
    ovf_nxt     = ovf;
    tail_dv_nxt = tail_dv;
    push        = 1'b0;
    push_dat    = '0;
    ok_inc      = 1'b0;
    err_inc     = 2'd0;
    len_upd     = 1'b0;

    case (state)
      IDLE: begin
        pre_nxt     = '0;
        len_nxt     = '0;
        bad_nxt     = 1'b0;
        ovf_nxt     = 1'b0;
        tail_dv_nxt = 1'b0;
        if (bus.RX_DV) begin
          if (bus.RXD == PRE_BYTE) begin
            state_nxt = PRE;
            pre_nxt   = 4'd1;
          end else if (bus.RXD == SFD_BYTE) begin
            state_nxt = DATA;
          end else begin
            state_nxt = DROP;
            err_inc   = 2'd1;
          end
        end
      end

      PRE: begin
        if (!bus.RX_DV) begin
          state_nxt = IDLE;
          err_inc   = 2'd1;
        end else if (bus.RX_ER) begin
          state_nxt = DROP;
          err_inc   = 2'd1;
        end else if (bus.RXD == PRE_BYTE) begin
          if (pre_cnt == 4'(PRE_MAX)) begin
            state_nxt = DROP;
            err_inc   = 2'd1;
          end else begin
            pre_nxt = pre_cnt + 4'd1;
          end
        end else if (bus.RXD == SFD_BYTE) begin
          state_nxt = DATA;
        end else begin
          state_nxt = DROP;
          err_inc   = 2'd1;
        end
      end

      DATA: begin
        if (bus.RX_DV) begin
          // len != 0 means the hold register carries an unpushed byte.
          if (len != '0) begin
            push     = 1'b1;
            push_dat = {1'b0, 1'b0, hold_dat};
            if (fifo_full) ovf_nxt = 1'b1;
          end
          hold_nxt = bus.RXD;
          len_nxt  = len_inc(len);
          if (bus.RX_ER) bad_nxt = 1'b1;
        end else if (len == '0) begin
          err_inc   = 2'd1;
          len_upd   = 1'b1;
          state_nxt = IDLE;
        end else if (!fifo_full) begin
          push      = 1'b1;
          push_dat  = {frame_err, 1'b1, hold_dat};
          ok_inc    = !frame_err;
          err_inc   = {1'b0, frame_err};
          len_upd   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = TAIL;
        end
      end

      TAIL: begin
        // Any frame that begins while the tail waits is lost; count it once.
        if (bus.RX_DV) tail_dv_nxt = 1'b1;
        if (!fifo_full) begin
          push      = 1'b1;
          push_dat  = {frame_err, 1'b1, hold_dat};
          ok_inc    = !frame_err;
          err_inc   = {1'b0, frame_err} + {1'b0, (bus.RX_DV | tail_dv)};
          len_upd   = 1'b1;
          state_nxt = bus.RX_DV ? DROP : IDLE;
        end
      end

      DROP: begin
        if (!bus.RX_DV) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pre_cnt       <= '0;
      hold_dat      <= '0;
      len           <= '0;
      bad           <= 1'b0;
      ovf           <= 1'b0;
      tail_dv       <= 1'b0;
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
      last_len      <= '0;
    end else begin
      state         <= state_nxt;
      pre_cnt       <= pre_nxt;
      hold_dat      <= hold_nxt;
      len           <= len_nxt;
      bad           <= bad_nxt;
      ovf           <= ovf_nxt;
      tail_dv       <= tail_dv_nxt;
      frame_ok_cnt  <= frame_ok_cnt + 16'(ok_inc);
      frame_err_cnt <= frame_err_cnt + 16'(err_inc);
      if (len_upd) last_len <= len;
    end
  end

  assign pop = !fifo_empty && bus.out_ready;

  gmii_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last;
  assign bus.out_err   = head.err;

endmodule

// File: doc/gmii_rx_sink.md
# gmii_rx_sink

Receive-side GMII endpoint for the 1000BASE-X PCS chain: consumes the receiver's RX_DV/RX_ER/RXD byte stream and strips preamble/SFD. It buffers frame payload in a small FIFO that presents a valid/ready byte stream with last/error markers, and keeps per-frame statistics. It is the counterpart to the tester's GMII transmit stimulus: it closes the loop tester → transmisor → synchronization → reciever → gmii_rx_sink.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥4
- MIN_LEN, 64, minimum good payload length in bytes (preamble/SFD excluded)
- MAX_LEN, 1518, maximum good payload length in bytes
- PRE_MAX, 7, maximum 0x55 bytes accepted before SFD
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- RX_DV  in  1  receive data valid from reciever
- RX_ER  in  1  receive error from reciever
- RXD  in  8  receive octet
- out_valid  out  1  FIFO head entry valid
- out_ready  in  1  downstream accepts head entry
- out_data  out  8  payload byte
- out_last  out  1  final byte of frame
- out_err  out  1  frame bad; meaningful only with out_last
- frame_ok_cnt  out  16  good frames, wraps at 2^16
- frame_err_cnt  out  16  bad or dropped frames, wraps at 2^16
- last_len  out  11  payload length of most recent completed frame, saturates at 2047

## Operation
- FSM states: IDLE, PRE, DATA, TAIL, DROP.
- IDLE: RX_DV=1 with RXD=0x55 → PRE (pre_cnt=1). RX_DV=1 with RXD=0xD5 → DATA. Any other RX_DV=1 → DROP.
- PRE: 0x55 increments pre_cnt; pre_cnt would exceed PRE_MAX → DROP. 0xD5 → DATA. Other byte, RX_ER=1, or RX_DV=0 → DROP, or IDLE if RX_DV=0. Every exit to DROP/IDLE from PRE increments frame_err_cnt exactly once.
- DATA: each byte is captured into a one-byte hold register. The previously held byte is pushed as {err=0,last=0}. len increments and saturates at 2047. RX_ER=1 sets sticky bad flag.
- RX_DV=0 in DATA: held byte pushed with last=1 and err=bad|len<MIN_LEN|len>MAX_LEN|overflow. If len=0, there is no push; frame_err_cnt increments. last_len=len, the matching counter increments, → IDLE.
- Overflow: a push while FIFO full drops the byte and sets sticky overflow. Only the tail entry waits: if full when the tail is due → TAIL. TAIL writes the tail on the first non-full cycle, updates stats, then → IDLE (if RX_DV=1 that cycle → DROP).
- While in TAIL, incoming bytes are ignored. A frame starting during TAIL is never delivered and is counted once in frame_err_cnt.
- DROP: ignore input until RX_DV=0 → IDLE.
- FIFO: push blocked when full, even if a pop occurs the same cycle. Pop on out_valid&out_ready. Empty FIFO → out_valid=0; out_data/last/err hold the last value.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_err=0, counters=0, last_len=0, FSM=IDLE, FIFO empty, hold/flags cleared.
- Latency: a byte on RXD in cycle c appears on out_data with out_valid=1 in cycle c+2 (hold register plus FIFO write), when the FIFO is not full.
- The tail byte is written on the edge that samples RX_DV=0. Stats update on that same edge, or on the TAIL write edge.
- Back-to-back frames with a 1-cycle RX_DV low gap are handled: IDLE re-arms the cycle after the tail.
- Reset asserted mid-frame clears everything immediately. A partial frame is neither delivered nor counted.

## Structure
- Shared header/package gmii_rx_defs: FSM state encoding, PRE_BYTE=8'h55, SFD_BYTE=8'hD5, FIFO entry width 10 ({err,last,data}).
- One sub-module, gmii_rx_fifo: synchronous FIFO, DEPTH×10, with full/empty flags and pointers one bit wider than the address.

## Test plan
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F, RX_DV low; out_ready=1 → 64 outputs, out_last only on 0x3F, out_err=0; frame_ok_cnt=1, last_len=64.
- Same framing with 10-byte payload → 10 outputs, last entry err=1; frame_err_cnt=1, last_len=10.
- 64-byte frame with RX_ER=1 on byte 20 → all 64 bytes delivered, tail err=1; frame_err_cnt=1.
- DEPTH=16, out_ready=0, 64-byte frame → 16 entries (0x00..0x0F, last=0), FSM in TAIL. Raise out_ready → tail 0x3F with last=1, err=1 written; frame_err_cnt=1.
- 3×0x55 then 0x12 → no FIFO writes, frame_err_cnt=1. A following good 64-byte frame is delivered normally.
- rst low during byte 30 of a frame → outputs/counters zero next cycle. A subsequent good frame yields frame_ok_cnt=1.
